// File: rtl/timer_counter_if.sv
// timer_counter_if: data-side bus from the M stage into the timer, plus read data and irq back
interface timer_counter_if;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    modport master (output addr, byteen, wdata, input rdata, irq);
    modport slave (input addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with level irq; TC_WRITE_BYTEEN_EN selects per-byte register writes
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t      state, state_nx;
    logic [3:0]  ctrl;
    logic [31:0] preset, count, mask;
    logic        irq_flag, hit, wr_ctrl, wr_preset, reload, expire, unused;
    assign hit       = bus.addr[31:4] == BASE_ADDR[31:4];
    assign wr_ctrl   = hit && |bus.byteen && bus.addr[3:2] == 2'd0;
    assign wr_preset = hit && |bus.byteen && bus.addr[3:2] == 2'd1;
    assign reload    = ctrl[2:1] == 2'b01;
    assign expire    = state == CNT && ctrl[0] && count == '0;
    assign unused    = ^bus.addr[1:0];
`ifdef TC_WRITE_BYTEEN_EN
    assign mask = {{8{bus.byteen[3]}}, {8{bus.byteen[2]}}, {8{bus.byteen[1]}}, {8{bus.byteen[0]}}};
`else
    assign mask = '1;
`endif
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    // next-state logic; reserved modes behave as one-shot
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = ctrl[0] ? LOAD : IDLE;
            LOAD:    state_nx = CNT;
            CNT:     state_nx = !ctrl[0] ? IDLE : count == '0 ? INT : CNT;
            default: state_nx = reload ? LOAD : IDLE;
        endcase
    end
    // registers: bus writes beat the one-shot EN clear, expiry beats the write-clear of irq_flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (wr_ctrl)                   ctrl <= (ctrl & ~mask[3:0]) | (bus.wdata[3:0] & mask[3:0]);
            else if (state == INT && !reload) ctrl <= {ctrl[3:1], 1'b0};
            if (wr_preset) preset <= (preset & ~mask) | (bus.wdata & mask);
            if (state == LOAD)                          count <= preset;
            else if (state == CNT && ctrl[0] && count != '0) count <= count - 32'd1;
            if (expire)                                    irq_flag <= 1'b1;
            else if (wr_ctrl || wr_preset || (state == INT && reload)) irq_flag <= 1'b0;
        end
    end
    // outputs: same-cycle read mux and level interrupt
    always_comb begin
        bus.rdata = !hit ? '0 :
                    bus.addr[3:2] == 2'd0 ? {28'd0, ctrl} :
                    bus.addr[3:2] == 2'd1 ? preset :
                    bus.addr[3:2] == 2'd2 ? count : '0;
        bus.irq   = ctrl[3] & irq_flag;
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: scoreboard bench for timer_counter register access, one-shot, auto-reload and reset behaviour
module tb_timer_counter;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];
    timer_counter_if bus();
    timer_counter #(.BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.addr = a;
        bus.wdata = d;
        bus.byteen = be;
        cycle();
        bus.byteen = 4'd0;
    endtask
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.addr = a;
        #1;
        check(tag, bus.rdata, exp_q.pop_front());
    endtask
    task automatic irq_is(input string tag, input logic exp);
        exp_q.push_back({31'd0, exp});
        check(tag, {31'd0, bus.irq}, exp_q.pop_front());
    endtask
    initial begin
        int rises, highs, last_rise, cnt2, max_cnt;
        logic prev;
        bus.addr = BASE;
        bus.wdata = '0;
        bus.byteen = 4'd0;
        #1;
        rd("rst_ctrl", BASE, 32'd0);
        rd("rst_preset", BASE + 4, 32'd0);
        rd("rst_count", BASE + 8, 32'd0);
        irq_is("rst_irq", 1'b0);
        reset = 1'b0;
        cycle();
        wr(BASE + 4, 32'd5, 4'hF);
        wr(BASE, 32'h1, 4'hF);
        cycle(); cycle();
        rd("pre_rst_count", BASE + 8, 32'd5);
        reset = 1'b1;
        #1;
        rd("async_rst_count", BASE + 8, 32'd0);
        rd("async_rst_ctrl", BASE, 32'd0);
        rd("async_rst_preset", BASE + 4, 32'd0);
        irq_is("async_rst_irq", 1'b0);
        reset = 1'b0;
        cycle();
        wr(BASE + 4, 32'd3, 4'hF);
        wr(BASE, 32'h9, 4'hF);
        cycle(); cycle();
        rd("m0_count3", BASE + 8, 32'd3);
        cycle(); rd("m0_count2", BASE + 8, 32'd2);
        cycle(); rd("m0_count1", BASE + 8, 32'd1);
        cycle(); rd("m0_count0", BASE + 8, 32'd0);
        cycle(); cycle();
        irq_is("m0_irq_set", 1'b1);
        rd("m0_en_cleared", BASE, 32'h8);
        cycle(); cycle(); cycle();
        irq_is("m0_irq_held", 1'b1);
        rd("m0_no_wrap", BASE + 8, 32'd0);
        wr(BASE, 32'h8, 4'hF);
        irq_is("m0_irq_cleared", 1'b0);
        wr(BASE + 4, 32'd2, 4'hF);
        wr(BASE, 32'hB, 4'hF);
        bus.addr = BASE + 8;
        rises = 0; highs = 0; last_rise = -1; cnt2 = 0; max_cnt = 0; prev = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            cycle();
            if (bus.irq) highs++;
            if (bus.irq && !prev) begin
                if (last_rise >= 0) check("m1_period", i - last_rise, 5);
                last_rise = i;
                rises++;
            end
            prev = bus.irq;
            if (bus.rdata == 32'd2) cnt2++;
            if (int'(bus.rdata) > max_cnt) max_cnt = int'(bus.rdata);
        end
        check("m1_pulse_width", highs, rises);
        check("m1_enough_pulses", {31'd0, rises >= 4}, 32'd1);
        check("m1_reload_seen", {31'd0, cnt2 >= 4}, 32'd1);
        check("m1_count_max", max_cnt, 2);
        wr(BASE, 32'h0, 4'hF);
        irq_is("m1_stop_irq", 1'b0);
        repeat (4) cycle();
        wr(BASE + 4, 32'd1, 4'hF);
        wr(BASE, 32'h1, 4'hF);
        repeat (8) cycle();
        irq_is("im0_irq_masked", 1'b0);
        rd("im0_en_cleared", BASE, 32'h0);
        wr(BASE, 32'h8, 4'hF);
        irq_is("im0_flag_cleared", 1'b0);
        rd("im0_ctrl", BASE, 32'h8);
        cycle();
        irq_is("im0_irq_stays_low", 1'b0);
        wr(BASE + 8, 32'hFFFF, 4'hF);
        rd("count_ro", BASE + 8, 32'd0);
        wr(BASE + 12, 32'hFFFF_FFFF, 4'hF);
        rd("off_c_reads0", BASE + 12, 32'd0);
        rd("off_c_ctrl_intact", BASE, 32'h8);
        wr(BASE + 32'h14, 32'hDEAD, 4'hF);
        rd("miss_write_ignored", BASE + 4, 32'd1);
        rd("miss_reads0", BASE + 32'h14, 32'd0);
        wr(BASE + 4, 32'h1122_3344, 4'hF);
        wr(BASE + 4, 32'h0000_AA00, 4'b0010);
`ifdef TC_WRITE_BYTEEN_EN
        rd("preset_byteen", BASE + 4, 32'h1122_AA44);
`else
        rd("preset_byteen", BASE + 4, 32'h0000_AA00);
`endif
        wr(BASE + 4, 32'd4, 4'hF);
        wr(BASE, 32'h1, 4'hF);
        cycle(); cycle();
        rd("cnt_start4", BASE + 8, 32'd4);
        wr(BASE + 4, 32'd9, 4'hF);
        rd("preset_wr_no_effect", BASE + 8, 32'd3);
        rd("preset_new", BASE + 4, 32'd9);
        wr(BASE, 32'h0, 4'hF);
        cycle(); cycle();
        rd("freeze_count", BASE + 8, 32'd2);
        wr(BASE, 32'h1, 4'hF);
        cycle(); cycle();
        rd("reenable_reload", BASE + 8, 32'd9);
        wr(BASE, 32'h0, 4'hF);
        cycle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
